// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared CPU widths, opcode field bounds and fetch FSM encoding
package instruction_fetch_pkg;
  localparam int XLEN = 16;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;
endpackage

// File: rtl/instruction_fetch_pc.sv
// instruction_fetch_pc: program counter with redirect load, +2 advance and hold
module instruction_fetch_pc
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            advance,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else if (load) pc <= target & ~XLEN'(1);
    else if (advance) pc <= pc + XLEN'(2);
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch FSM and IF/ID register feeding the decoder,
// with redirect flush, halt detection and out-of-range fetch fault.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000,
  parameter int IMEM_BYTES = 128,
  parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic            Clock,
  input  logic            ResetN,
  input  logic            Run,
  output logic [XLEN-1:0] PCAddress,
  input  logic [XLEN-1:0] Instruction,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectTarget,
  input  logic            DecodeReady,
  output logic            InstrValid,
  output logic [XLEN-1:0] InstrOut,
  output logic [XLEN-1:0] InstrPC,
  output logic            Halted,
  output logic            FetchFault
);
  localparam logic [XLEN-1:0] PC_MAX = XLEN'(IMEM_BYTES - 2);
  logic [1:0] state;
  logic redir, cap_ok, fault, capture, is_halt;
  // Redirect takes priority over stall, halt and fault in the same cycle
  always_comb begin
    redir = Redirect && (state == ST_IDLE || state == ST_FETCH);
    cap_ok = state == ST_FETCH && Run && (!InstrValid || DecodeReady) && !redir;
    fault = cap_ok && PCAddress > PC_MAX;
    capture = cap_ok && !fault;
    is_halt = Instruction[OP_HI:OP_LO] == HALT_OPCODE;
  end
  instruction_fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk(Clock),
    .rst_n(ResetN),
    .load(redir),
    .advance(capture && !is_halt),
    .target(RedirectTarget),
    .pc(PCAddress)
  );
  always_ff @(posedge Clock or negedge ResetN)
    if (!ResetN) begin
      state <= ST_IDLE;
      InstrValid <= 1'b0;
      InstrOut <= '0;
      InstrPC <= '0;
    end else begin
      if (redir) InstrValid <= 1'b0;
      else if (capture) begin
        InstrValid <= 1'b1;
        InstrOut <= Instruction;
        InstrPC <= PCAddress;
      end else if (DecodeReady) InstrValid <= 1'b0;
      if (fault) state <= ST_FAULT;
      else if (capture && is_halt) state <= ST_HALT;
      else if (state == ST_IDLE && Run) state <= ST_FETCH;
      else if (state == ST_FETCH && !Run) state <= ST_IDLE;
    end
  assign Halted = state == ST_HALT;
  assign FetchFault = state == ST_FAULT;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and random stimulus against a behavioural fetch
// model; accepted instructions are scoreboarded in order by a separate monitor.
module tb_instruction_fetch;
  logic Clock = 1'b0, ResetN = 1'b0, Run = 1'b0, Redirect = 1'b0, DecodeReady = 1'b0;
  logic [15:0] RedirectTarget = '0;
  logic [15:0] Instruction, PCAddress, InstrOut, InstrPC;
  logic InstrValid, Halted, FetchFault;
  logic [7:0] mem [128];
  int checks = 0, errors = 0;
  typedef enum int {M_IDLE, M_FETCH, M_HALT, M_FAULT} mstate_t;
  mstate_t m_st = M_IDLE, n_st = M_IDLE;
  logic [15:0] m_pc = '0, m_out = '0, m_ipc = '0, n_pc, n_out, n_ipc;
  logic m_valid = 1'b0, n_valid;
  logic [31:0] exp_q[$];

  always #5 Clock = ~Clock;

  function automatic logic [15:0] imem(input logic [15:0] a);
    return (int'(a) + 1 < 128) ? {mem[a[6:0]], mem[a[6:0] + 7'd1]} : 16'hDEAD;
  endfunction
  assign Instruction = imem(PCAddress);

  instruction_fetch dut (
    .Clock(Clock), .ResetN(ResetN), .Run(Run), .PCAddress(PCAddress),
    .Instruction(Instruction), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
    .DecodeReady(DecodeReady), .InstrValid(InstrValid), .InstrOut(InstrOut),
    .InstrPC(InstrPC), .Halted(Halted), .FetchFault(FetchFault)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_pc = 16'h0000; m_out = '0; m_ipc = '0; m_valid = 1'b0;
    exp_q.delete();
  endtask

  // One clock of fetch behaviour from the current inputs; accepted words go to the scoreboard
  task automatic model_eval();
    logic redir, want;
    logic [15:0] w;
    n_st = m_st; n_pc = m_pc; n_out = m_out; n_ipc = m_ipc; n_valid = m_valid;
    redir = Redirect && (m_st == M_IDLE || m_st == M_FETCH);
    want = m_st == M_FETCH && Run && (!m_valid || DecodeReady) && !redir;
    w = imem(m_pc);
    if (m_valid && DecodeReady) begin
      exp_q.push_back({m_ipc, m_out});
      n_valid = 1'b0;
    end
    if (redir) begin
      n_pc = RedirectTarget & 16'hFFFE;
      n_valid = 1'b0;
    end else if (want && int'(m_pc) + 1 >= 128) n_st = M_FAULT;
    else if (want) begin
      n_out = w; n_ipc = m_pc; n_valid = 1'b1;
      if (w[15:12] == 4'hF) n_st = M_HALT;
      else n_pc = m_pc + 16'd2;
    end
    if (m_st == M_IDLE && Run) n_st = M_FETCH;
    else if (m_st == M_FETCH && !Run) n_st = M_IDLE;
  endtask

  task automatic step(input logic run, input logic dr, input logic rd, input logic [15:0] tgt);
    @(negedge Clock);
    Run = run; DecodeReady = dr; Redirect = rd; RedirectTarget = tgt;
    #1 model_eval();
    @(posedge Clock);
    m_st = n_st; m_pc = n_pc; m_out = n_out; m_ipc = n_ipc; m_valid = n_valid;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    ResetN = 1'b0; Run = 1'b0; DecodeReady = 1'b0; Redirect = 1'b0;
    model_reset();
    @(posedge Clock);
    #1 ResetN = 1'b1;
  endtask

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge Clock);
      #2;
      check("pc_address", PCAddress, m_pc);
      check("instr_valid", 16'(InstrValid), 16'(m_valid));
      check("halted", 16'(Halted), 16'(m_st == M_HALT));
      check("fetch_fault", 16'(FetchFault), 16'(m_st == M_FAULT));
      if (InstrValid && DecodeReady) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL accept: got %h@%h expected no instruction", InstrOut, InstrPC);
        end else begin
          e = exp_q.pop_front();
          check("accept_word", InstrOut, e[15:0]);
          check("accept_pc", InstrPC, e[31:16]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h7;
      mem[2*i] = w[15:8];
      mem[2*i+1] = w[7:0];
    end
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    mem[4] = 8'h11; mem[5] = 8'h11; mem[6] = 8'hF0; mem[7] = 8'h00;
    #1;
    check("reset_pc", PCAddress, 16'h0000);
    check("reset_out", InstrOut, 16'h0000);
    check("reset_ipc", InstrPC, 16'h0000);
    check("reset_valid", 16'(InstrValid), 16'h0000);
    do_reset();
    step(1, 1, 0, 0);
    check("idle_no_capture", 16'(InstrValid), 16'h0000);
    step(1, 1, 0, 0); #1;
    check("first_word", InstrOut, 16'h1234);
    check("first_pc", InstrPC, 16'h0000);
    step(1, 1, 0, 0); #1;
    check("second_word", InstrOut, 16'h5678);
    check("second_pc", InstrPC, 16'h0002);
    check("pc_after_two", PCAddress, 16'h0004);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); #1;
    check("stall_word", InstrOut, 16'h5678);
    check("stall_pc", PCAddress, 16'h0004);
    step(1, 1, 0, 0); #1;
    check("resume_word", InstrOut, 16'h1111);
    check("resume_pc", InstrPC, 16'h0004);
    step(1, 0, 1, 16'h0021); #1;
    check("redirect_flush", 16'(InstrValid), 16'h0000);
    check("redirect_pc", PCAddress, 16'h0020);
    step(1, 1, 0, 0); #1;
    check("target_valid", 16'(InstrValid), 16'h0001);
    check("target_word", InstrOut, imem(16'h0020));
    check("target_ipc", InstrPC, 16'h0020);
    step(1, 1, 1, 16'h0006);
    step(1, 1, 0, 0); #1;
    check("halt_word", InstrOut, 16'hF000);
    check("halt_ipc", InstrPC, 16'h0006);
    check("halted", 16'(Halted), 16'h0001);
    check("halt_pc", PCAddress, 16'h0006);
    step(1, 1, 1, 16'h0040); #1;
    check("halt_drained", 16'(InstrValid), 16'h0000);
    check("halt_ignores_redirect", PCAddress, 16'h0006);
    do_reset();
    step(1, 1, 1, 16'h007F); #1;
    check("edge_pc", PCAddress, 16'h007E);
    step(1, 1, 0, 0); #1;
    check("edge_capture_ipc", InstrPC, 16'h007E);
    check("edge_pc_next", PCAddress, 16'h0080);
    step(1, 1, 0, 0); #1;
    check("fault_set", 16'(FetchFault), 16'h0001);
    check("fault_no_capture", 16'(InstrValid), 16'h0000);
    step(1, 1, 1, 16'h0010); #1;
    check("fault_sticky", 16'(FetchFault), 16'h0001);
    check("fault_ignores_redirect", PCAddress, 16'h0080);
    do_reset(); #1;
    check("fault_cleared", 16'(FetchFault), 16'h0000);
    step(1, 1, 1, 16'h0006);
    step(1, 1, 1, 16'h0010); #1;
    check("redirect_beats_halt_pc", PCAddress, 16'h0010);
    check("redirect_beats_halt", 16'(Halted), 16'h0000);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        logic [15:0] tgt;
        tgt = ($urandom % 10 == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
        step(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0, tgt);
      end
    end
    @(negedge Clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
